lsu: RTL

- Load/store unit: the initiator side of the data-memory interface (`dm_w`/`dm_r`/`addr`/`wdata`/`dm_op`/`rdata`).
- Sits between the pipeline MEM stage and the data memory.
- Accepts one request at a time over a valid/ready handshake and registers it.
- Checks alignment and op legality, drives the memory for exactly one cycle, captures read data and returns a response held until the consumer takes it.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_check.sv | 48 ++++
 rtl/lsu.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg -- shared definitions for the load/store unit.
//
// Holds the data-memory op codes (shared with the dm block), the LSU FSM
// state type, and small op-classification helpers used by the legality
// decode.
//
// Configuration macro: LSU_BOUNDS_CHECK_EN (consumed by lsu_check / lsu).
// -----------------------------------------------------------------------------
package lsu_pkg;

  // Data-memory access types. Loads use WD/BS/BZ/HS/HZ, stores use WD/SB/SH.
  localparam logic [2:0] DM_OP_WD = 3'd0;  // 32-bit word
  localparam logic [2:0] DM_OP_BS = 3'd1;  // byte, sign-extended
  localparam logic [2:0] DM_OP_BZ = 3'd2;  // byte, zero-extended
  localparam logic [2:0] DM_OP_HS = 3'd3;  // half, sign-extended
  localparam logic [2:0] DM_OP_HZ = 3'd4;  // half, zero-extended
  localparam logic [2:0] DM_OP_SB = 3'd5;  // store byte
  localparam logic [2:0] DM_OP_SH = 3'd6;  // store half

  typedef enum logic [1:0] {
    LSU_S_IDLE   = 2'd0,
    LSU_S_ACCESS = 2'd1,
    LSU_S_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic is_store_op(input logic [2:0] op);
    return (op == DM_OP_WD) || (op == DM_OP_SB) || (op == DM_OP_SH);
  endfunction

  function automatic logic is_load_op(input logic [2:0] op);
    return (op == DM_OP_WD) || (op == DM_OP_BS) || (op == DM_OP_BZ) ||
           (op == DM_OP_HS) || (op == DM_OP_HZ);
  endfunction

  // Ops that move a halfword and therefore need addr[0] == 0.
  function automatic logic is_half_op(input logic [2:0] op);
    return (op == DM_OP_HS) || (op == DM_OP_HZ) || (op == DM_OP_SH);
  endfunction

endpackage

// File: rtl/lsu_check.sv
// -----------------------------------------------------------------------------
// lsu_check -- combinational request legality decode.
//
// Flags a request as erroneous when:
//   - the op is not legal for the direction (store: WD/SB/SH,
//     load: BS/BZ/HS/HZ/WD),
//   - a halfword op has addr[0] set, or a word op has addr[1:0] != 0,
//   - (LSU_BOUNDS_CHECK_EN only) the word index addr[31:2] >= NMEM.
// Byte ops are never misaligned.
//
// Ports:
//   we_i    1   1 = store, 0 = load
//   op_i    3   DM_OP_* access type
//   addr_i  32  byte address
//   err_o   1   request must not reach memory
// -----------------------------------------------------------------------------
module lsu_check
  import lsu_pkg::*;
#(
  parameter int unsigned NMEM = 256
) (
  input  logic        we_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  output logic        err_o
);

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  logic legal;
  logic misaligned;
  logic out_of_bounds;

  always_comb begin
    legal         = we_i ? is_store_op(op_i) : is_load_op(op_i);
    misaligned    = (is_half_op(op_i) && addr_i[0]) ||
                    ((op_i == DM_OP_WD) && (addr_i[1:0] != 2'b00));
    // The compare is always built so NMEM stays referenced; it only
    // contributes to err_o when the bounds feature is compiled in.
    out_of_bounds = ({2'b00, addr_i[31:2]} >= NMEM);
    err_o         = !legal || misaligned || (BoundsEn && out_of_bounds);
  end

endmodule

// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu -- load/store unit, initiator side of the data-memory interface.
//
// Takes one request at a time from the MEM stage over a valid/ready
// handshake, registers it, rejects illegal/misaligned requests without
// touching memory, otherwise drives memory for exactly one cycle (ACCESS),
// captures load data and presents a response until the consumer takes it.
//
//   IDLE   --req_valid, ok-->  ACCESS --> RESP --resp_ready--> IDLE
//   IDLE   --req_valid, err--------------> RESP
//
// Configuration macro: LSU_BOUNDS_CHECK_EN -- when defined, word indices
// >= NMEM are rejected as errors (see lsu_check).
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_we/op/addr/wdata/tag       request fields
//   resp_valid/resp_ready          response handshake
//   resp_rdata/resp_tag/resp_err   response fields (rdata 0 for stores/errors)
//   dm_w/dm_r                      memory write strobe / read enable
//   dm_addr/dm_wdata/dm_op         memory request, held between accesses
//   dm_rdata                       memory read data (combinational)
// -----------------------------------------------------------------------------
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned NMEM = 256,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_op,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [TAGW-1:0] req_tag,

  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [31:0]     resp_rdata,
  output logic [TAGW-1:0] resp_tag,
  output logic            resp_err,

  output logic            dm_w,
  output logic            dm_r,
  output logic [31:0]     dm_addr,
  output logic [31:0]     dm_wdata,
  output logic [2:0]      dm_op,
  input  logic [31:0]     dm_rdata
);

  lsu_state_e      state_q, state_d;
  logic            we_q,    we_d;
  logic [2:0]      op_q,    op_d;
  logic [31:0]     addr_q,  addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [TAGW-1:0] tag_q,   tag_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q,   err_d;

  logic            chk_err;

  // Legality is decided on the live request so the error path can skip
  // ACCESS entirely.
  lsu_check #(
    .NMEM (NMEM)
  ) u_check (
    .we_i   (req_we),
    .op_i   (req_op),
    .addr_i (req_addr),
    .err_o  (chk_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LSU_S_IDLE;
      we_q    <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      tag_q   <= tag_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    tag_d   = tag_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      LSU_S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          tag_d   = req_tag;
          // Cleared here so stores and rejected requests report zero data.
          rdata_d = '0;
          err_d   = chk_err;
          state_d = chk_err ? LSU_S_RESP : LSU_S_ACCESS;
        end
      end
      LSU_S_ACCESS: begin
        rdata_d = we_q ? '0 : dm_rdata;
        state_d = LSU_S_RESP;
      end
      LSU_S_RESP: begin
        if (resp_ready) begin
          state_d = LSU_S_IDLE;
        end
      end
      default: begin
        state_d = LSU_S_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready  = (state_q == LSU_S_IDLE);
    resp_valid = (state_q == LSU_S_RESP);
    resp_rdata = rdata_q;
    resp_tag   = tag_q;
    resp_err   = err_q;

    // The write strobe is gated by rst_n so a store caught by reset in its
    // ACCESS cycle never commits.
    dm_r     = (state_q == LSU_S_ACCESS) && !we_q;
    dm_w     = (state_q == LSU_S_ACCESS) && we_q && rst_n;
    dm_addr  = addr_q;
    dm_wdata = wdata_q;
    dm_op    = op_q;
  end

endmodule
